// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: drives a req/ack bus transaction, stalls the
// pipeline while it is outstanding, steers byte lanes and extends load data.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        mem_error
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone, StError} state_e;

  localparam logic [15:0] LastCnt = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        bus_req_q, bus_we_q, load_valid_q, mem_error_q, sign_q;
  logic [31:0] bus_addr_q, bus_wdata_q, load_data_q;
  logic [3:0]  bus_be_q;
  logic [1:0]  size_q, off_q;

  logic        is_mem, misaligned, start, bad;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, load_ext;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign is_mem = mem_read | mem_write;

  always_comb begin
    misaligned = 1'b0;
    unique case (mem_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = aluout[0];
      2'b10:   misaligned = |aluout[1:0];
      default: misaligned = 1'b1;  // size 11 is reserved
    endcase
  end

  assign start = (mem_read ^ mem_write) & ~misaligned;
  assign bad   = (mem_read & mem_write) | (is_mem & misaligned);

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = writedata;
    case (mem_size)
      2'b00: begin
        be_n    = 4'b0001 << aluout[1:0];
        wdata_n = {4{writedata[7:0]}};
      end
      2'b01: begin
        be_n    = aluout[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{writedata[15:0]}};
      end
      default: ;
    endcase
  end

  assign rbyte = bus_rdata[{off_q, 3'b000} +: 8];
  assign rhalf = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    load_ext = bus_rdata;
    case (size_q)
      2'b00:   load_ext = {{24{sign_q & rbyte[7]}}, rbyte};
      2'b01:   load_ext = {{16{sign_q & rhalf[15]}}, rhalf};
      default: load_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (bad) begin
          state_d = StError;
        end else if (start) begin
          state_d = StAccess;
          cnt_d   = '0;
        end
      end
      StAccess: begin
        if (bus_ack) begin
          state_d = StDone;
        end else if (cnt_q == LastCnt) begin
          state_d = StError;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign stall = !reset && (((state_q == StIdle) && is_mem) || (state_q == StAccess));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      mem_error_q  <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      sign_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= (state_d == StAccess);
      load_valid_q <= (state_d == StDone) && !bus_we_q;
      if ((state_q == StIdle) && start) begin
        bus_we_q    <= mem_write;
        bus_addr_q  <= {aluout[31:2], 2'b00};
        bus_be_q    <= be_n;
        bus_wdata_q <= wdata_n;
        size_q      <= mem_size;
        off_q       <= aluout[1:0];
        sign_q      <= mem_sign;
      end
      if ((state_q == StAccess) && bus_ack && !bus_we_q) begin
        load_data_q <= load_ext;
      end
      if (state_d == StError) begin
        load_data_q <= '0;
        mem_error_q <= 1'b1;
      end
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign mem_error  = mem_error_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized back-to-back
// accesses checked against an arithmetic model of lanes, extension and timing.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_read, mem_write, mem_sign, bus_ack;
  logic [1:0]  mem_size;
  logic [31:0] aluout, writedata, bus_rdata;

  logic        bus_req, bus_we, stall, load_valid, mem_error;
  logic [31:0] bus_addr, bus_wdata, load_data;
  logic [3:0]  bus_be;
  logic        t3_req, t3_we, t3_stall, t3_lv, t3_err;
  logic [31:0] t3_addr, t3_wdata, t3_ld;
  logic [3:0]  t3_be;

  mem_access_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_sign(mem_sign), .aluout(aluout), .writedata(writedata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall(stall),
    .load_data(load_data), .load_valid(load_valid), .mem_error(mem_error)
  );

  mem_access_ctrl #(.TIMEOUT(3)) dut_t3 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_sign(mem_sign), .aluout(aluout), .writedata(writedata),
    .bus_req(t3_req), .bus_we(t3_we), .bus_addr(t3_addr), .bus_be(t3_be),
    .bus_wdata(t3_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall(t3_stall),
    .load_data(t3_ld), .load_valid(t3_lv), .mem_error(t3_err)
  );

  // Observed instance: 0 = main (TIMEOUT 16), 1 = short-timeout instance.
  logic        sel = 1'b0;
  logic        o_req, o_we, o_stall, o_lv, o_err;
  logic [31:0] o_addr, o_wdata, o_ld;
  logic [3:0]  o_be;

  always_comb begin
    o_req = sel ? t3_req : bus_req;
    o_we = sel ? t3_we : bus_we;
    o_stall = sel ? t3_stall : stall;
    o_lv = sel ? t3_lv : load_valid;
    o_err = sel ? t3_err : mem_error;
    o_addr = sel ? t3_addr : bus_addr;
    o_wdata = sel ? t3_wdata : bus_wdata;
    o_ld = sel ? t3_ld : load_data;
    o_be = sel ? t3_be : bus_be;
  end

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic sgn, input logic [1:0] off);
    longint v;
    if (size == 2'd0) begin
      v = (w >> (8 * int'(off))) & 32'hFF;
      if (sgn && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = (w >> (16 * int'(off[1]))) & 32'hFFFF;
      if (sgn && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [1:0] off);
    int n, base;
    logic [3:0] be;
    n = 1 << int'(size);
    base = (int'(off) / n) * n;
    for (int b = 0; b < 4; b++) be[b] = (b >= base) && (b < base + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return (wd & 32'hFF) * 32'h01010101;
    if (size == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  // Drives one instruction from its MEM-stage cycle 0 until the cycle stall drops, acking
  // on the ack_at-th request cycle (0 = never); records what the observed instance did.
  task automatic run_access(
    input logic rd, input logic wr, input logic [1:0] size, input logic sgn,
    input logic [31:0] addr, input logic [31:0] wd, input int ack_at, input logic [31:0] rdata,
    input int budget,
    output int n_stall, output int n_req, output logic [31:0] s_addr, output logic [31:0] s_wdata,
    output logic [3:0] s_be, output logic s_we, output logic unstable,
    output logic lv_end, output logic [31:0] ld_end, output logic err_end, output logic to);
    mem_read = rd; mem_write = wr; mem_size = size; mem_sign = sgn;
    aluout = addr; writedata = wd; bus_ack = 1'b0; bus_rdata = $urandom;
    n_stall = 0; n_req = 0; unstable = 1'b0; to = 1'b1;
    s_addr = '0; s_wdata = '0; s_be = '0; s_we = 1'b0;
    lv_end = 1'b0; ld_end = '0; err_end = 1'b0;
    for (int c = 0; c < budget; c++) begin
      #1;
      if (o_stall) n_stall++;
      if (o_req) begin
        n_req++;
        if (n_req == 1) begin
          s_addr = o_addr; s_wdata = o_wdata; s_be = o_be; s_we = o_we;
        end else if (o_addr !== s_addr || o_wdata !== s_wdata || o_be !== s_be || o_we !== s_we) begin
          unstable = 1'b1;
        end
        bus_ack = (n_req == ack_at);
        bus_rdata = bus_ack ? rdata : $urandom;
      end else begin
        // Stray acks outside ACCESS must have no effect.
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
      if (!o_stall) begin
        lv_end = o_lv; ld_end = o_ld; err_end = o_err; to = 1'b0;
        break;
      end
      @(posedge clk); @(negedge clk);
    end
    @(posedge clk); @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
  endtask

  int n_stall, n_req;
  logic [31:0] s_addr, s_wdata, ld_end;
  logic [3:0] s_be;
  logic s_we, unstable, lv_end, err_end, to;

  task automatic test_reset();
    reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2; mem_sign = 1'b0;
    aluout = 32'h100; writedata = '0; bus_ack = 1'b0; bus_rdata = '0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b, want 0", stall); end
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, load_data, load_valid, mem_error, stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wd=%h ld=%h lv=%b err=%b stall=%b, want all 0",
               bus_req, bus_we, bus_addr, bus_be, bus_wdata, load_data, load_valid, mem_error, stall);
    end
    mem_read = 1'b0; reset = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_word_load();
    run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 20,
               n_stall, n_req, s_addr, s_wdata, s_be, s_we, unstable, lv_end, ld_end, err_end, to);
    checks++;
    if (to || n_stall !== 2 || n_req !== 1) begin
      errors++; $display("FAIL word_load_timing: got to=%b stall=%0d req=%0d, want to=0 stall=2 req=1", to, n_stall, n_req);
    end
    checks++;
    if (s_addr !== 32'h100 || s_be !== 4'hF || s_we !== 1'b0) begin
      errors++; $display("FAIL word_load_bus: got addr=%h be=%b we=%b, want 100 1111 0", s_addr, s_be, s_we);
    end
    checks++;
    if (lv_end !== 1'b1 || ld_end !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_load_data: got lv=%b ld=%h, want 1 deadbeef", lv_end, ld_end);
    end
  endtask

  task automatic test_byte_store();
    run_access(1'b0, 1'b1, 2'd0, 1'b0, 32'h203, 32'h000000A5, 4, 32'h0, 20,
               n_stall, n_req, s_addr, s_wdata, s_be, s_we, unstable, lv_end, ld_end, err_end, to);
    checks++;
    if (to || n_stall !== 5 || n_req !== 4 || unstable) begin
      errors++; $display("FAIL byte_store_timing: got to=%b stall=%0d req=%0d unstable=%b, want 0 5 4 0",
                         to, n_stall, n_req, unstable);
    end
    checks++;
    if (s_addr !== 32'h200 || s_be !== 4'b1000 || s_wdata !== 32'hA5A5A5A5 || s_we !== 1'b1) begin
      errors++; $display("FAIL byte_store_bus: got addr=%h be=%b wd=%h we=%b, want 200 1000 a5a5a5a5 1",
                         s_addr, s_be, s_wdata, s_we);
    end
    checks++;
    if (lv_end !== 1'b0 || ld_end !== 32'hDEADBEEF) begin
      errors++; $display("FAIL byte_store_noload: got lv=%b ld=%h, want 0 deadbeef", lv_end, ld_end);
    end
  endtask

  task automatic test_misaligned();
    run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 1, 32'h11111111, 20,
               n_stall, n_req, s_addr, s_wdata, s_be, s_we, unstable, lv_end, ld_end, err_end, to);
    checks++;
    if (to || n_stall !== 1 || n_req !== 0) begin
      errors++; $display("FAIL misaligned_timing: got to=%b stall=%0d req=%0d, want 0 1 0", to, n_stall, n_req);
    end
    checks++;
    if (err_end !== 1'b1 || ld_end !== 32'h0 || lv_end !== 1'b0) begin
      errors++; $display("FAIL misaligned_error: got err=%b ld=%h lv=%b, want 1 0 0", err_end, ld_end, lv_end);
    end
    // Non-memory instruction afterwards: no stall, error stays set.
    run_access(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1, 32'h0, 20,
               n_stall, n_req, s_addr, s_wdata, s_be, s_we, unstable, lv_end, ld_end, err_end, to);
    checks++;
    if (to || n_stall !== 0 || n_req !== 0 || err_end !== 1'b1) begin
      errors++; $display("FAIL error_sticky: got to=%b stall=%0d req=%0d err=%b, want 0 0 0 1",
                         to, n_stall, n_req, err_end);
    end
  endtask

  task automatic test_half_load();
    logic [31:0] want;
    for (int s = 1; s >= 0; s--) begin
      want = (s == 1) ? 32'hFFFF8001 : 32'h00008001;
      run_access(1'b1, 1'b0, 2'd1, 1'(s), 32'h2, 32'h0, 1, 32'h80017FFF, 20,
                 n_stall, n_req, s_addr, s_wdata, s_be, s_we, unstable, lv_end, ld_end, err_end, to);
      checks++;
      if (to || lv_end !== 1'b1 || ld_end !== want || s_be !== 4'b1100) begin
        errors++; $display("FAIL half_load_sign%0d: got to=%b lv=%b ld=%h be=%b, want 0 1 %h 1100",
                           s, to, lv_end, ld_end, s_be, want);
      end
    end
  endtask

  task automatic test_reset_in_access();
    mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2; aluout = 32'h300; bus_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus_req !== 1'b1) begin errors++; $display("FAIL rst_acc_req: got %b, want 1", bus_req); end
    @(posedge clk); @(negedge clk);
    reset = 1'b1; mem_read = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, load_data, load_valid, mem_error, stall} !== '0) begin
      errors++;
      $display("FAIL rst_acc_outputs: got req=%b addr=%h be=%b wd=%h ld=%h lv=%b err=%b stall=%b, want all 0",
               bus_req, bus_addr, bus_be, bus_wdata, load_data, load_valid, mem_error, stall);
    end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL rst_acc_abandon: got req=%b stall=%b, want 0 0", bus_req, stall);
    end
  endtask

  // Randomized back-to-back instructions against the arithmetic model.
  task automatic test_back_to_back();
    logic rd, wr, sgn, legal, err_m;
    logic [1:0] size;
    logic [31:0] addr, wd, rdata, last;
    int kind, ack_at, exp_stall, exp_req;
    err_m = 1'b0; last = '0;
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      rd = (kind == 1) || (kind >= 2 && kind <= 5);
      wr = (kind == 1) || (kind >= 6);
      size = 2'($urandom_range(0, 3));
      if (size == 2'd3 && $urandom_range(0, 3) != 0) size = 2'd2;
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr = addr & ~((32'd1 << size) - 32'd1);
      wd = $urandom; rdata = $urandom; sgn = 1'($urandom_range(0, 1));
      ack_at = $urandom_range(1, 6);
      run_access(rd, wr, size, sgn, addr, wd, ack_at, rdata, 20,
                 n_stall, n_req, s_addr, s_wdata, s_be, s_we, unstable, lv_end, ld_end, err_end, to);
      legal = (rd != wr) && (size != 2'd3) && ((addr % (32'd1 << size)) == 0);
      if (!rd && !wr) begin
        exp_stall = 0; exp_req = 0;
      end else if (!legal) begin
        exp_stall = 1; exp_req = 0; err_m = 1'b1; last = '0;
      end else begin
        exp_stall = ack_at + 1; exp_req = ack_at;
        if (rd) last = model_load(rdata, size, sgn, addr[1:0]);
      end
      checks++;
      if (to || n_stall !== exp_stall || n_req !== exp_req || unstable) begin
        errors++; $display("FAIL rand%0d_timing: got to=%b stall=%0d req=%0d unstable=%b, want 0 %0d %0d 0",
                           i, to, n_stall, n_req, unstable, exp_stall, exp_req);
      end
      checks++;
      if (lv_end !== (legal && rd) || ld_end !== last || err_end !== err_m) begin
        errors++; $display("FAIL rand%0d_result: got lv=%b ld=%h err=%b, want %b %h %b",
                           i, lv_end, ld_end, err_end, legal && rd, last, err_m);
      end
      if (legal) begin
        checks++;
        if (s_addr !== (addr & 32'hFFFFFFFC) || s_be !== model_be(size, addr[1:0]) || s_we !== wr ||
            (wr && s_wdata !== model_wdata(size, wd))) begin
          errors++; $display("FAIL rand%0d_bus: got addr=%h be=%b we=%b wd=%h, want %h %b %b %h",
                             i, s_addr, s_be, s_we, s_wdata, addr & 32'hFFFFFFFC,
                             model_be(size, addr[1:0]), wr, model_wdata(size, wd));
        end
      end
    end
  endtask

  task automatic test_timeout();
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; sel = 1'b1;
    run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, 32'h0, 20,
               n_stall, n_req, s_addr, s_wdata, s_be, s_we, unstable, lv_end, ld_end, err_end, to);
    checks++;
    if (to || n_req !== 3 || n_stall !== 4) begin
      errors++; $display("FAIL timeout_timing: got to=%b req=%0d stall=%0d, want 0 3 4", to, n_req, n_stall);
    end
    checks++;
    if (err_end !== 1'b1 || ld_end !== 32'h0 || lv_end !== 1'b0) begin
      errors++; $display("FAIL timeout_error: got err=%b ld=%h lv=%b, want 1 0 0", err_end, ld_end, lv_end);
    end
    for (int k = 0; k < 2; k++) begin
      bus_ack = 1'b1; bus_rdata = 32'h12345678;
      @(posedge clk); @(negedge clk);
      checks++;
      if (o_req !== 1'b0 || o_lv !== 1'b0 || o_ld !== 32'h0 || o_err !== 1'b1 || o_stall !== 1'b0) begin
        errors++; $display("FAIL late_ack%0d: got req=%b lv=%b ld=%h err=%b stall=%b, want 0 0 0 1 0",
                           k, o_req, o_lv, o_ld, o_err, o_stall);
      end
    end
    bus_ack = 1'b0; sel = 1'b0; reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_misaligned();
    test_half_load();
    test_reset_in_access();
    test_back_to_back();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
